instr_prefetch_buffer: RTL and testbench

//   Instruction fetch front end between the pipelined core's fetch port and a

---
 rtl/instr_prefetch_buffer.sv | 144 ++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer
//   Instruction fetch front end. Sequential word fetches are issued ahead of
//   the core. In-order memory responses are buffered with their PCs in a
//   DEPTH-entry FIFO. A taken branch/jump redirect flushes the FIFO and
//   restarts fetching at the new PC. Responses still in flight at that point
//   are counted and discarded when they arrive.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   redirect_valid/pc   taken redirect from EX and its target (bits [1:0] ignored)
//   fetch_ready         core accepts the head entry
//   fetch_valid/pc/instr head entry presented to the core (pc/instr are 0 when empty)
//   mem_req_valid/ready request handshake, mem_req_addr is the word-aligned fetch address
//   mem_rsp_valid/data  in-order response, always accepted
module instr_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  // Entry storage carries no reset; occupancy is tracked by count_q alone.
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [31:0]   issue_pc_q, issue_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;

  logic [CW-1:0] live;
  logic [CW:0]   occupancy;
  logic [CW-1:0] inflight_nxt;
  logic [31:0]   redirect_word;
  logic          fifo_empty;
  logic          req_fire;
  logic          push;
  logic          pop;

  assign redirect_word = redirect_pc & 32'hFFFF_FFFC;
  assign fifo_empty    = (count_q == '0);

  // Credit: buffered entries plus responses that will still be kept must fit
  // in the FIFO, so a push can never find it full.
  assign live      = inflight_q - drop_q;
  assign occupancy = {1'b0, count_q} + {1'b0, live};

  assign mem_req_valid = !rst && !redirect_valid &&
                         (inflight_q < CW'(DEPTH)) &&
                         (occupancy < (CW + 1)'(DEPTH));
  assign mem_req_addr  = issue_pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign fetch_valid = !fifo_empty && !redirect_valid;
  assign fetch_pc    = fifo_empty ? 32'h0 : pc_mem[rd_ptr_q];
  assign fetch_instr = fifo_empty ? 32'h0 : instr_mem[rd_ptr_q];
  assign pop         = fetch_valid && fetch_ready;

  // A response arriving in a redirect cycle belongs to the old stream.
  assign push = mem_rsp_valid && (drop_q == '0) && !redirect_valid;

  assign inflight_nxt = inflight_q + CW'(req_fire) - CW'(mem_rsp_valid);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_nxt;
    drop_d     = drop_q;
    issue_pc_d = issue_pc_q;
    rsp_pc_d   = rsp_pc_q;
    if (redirect_valid) begin
      // Everything still outstanding, minus a response consumed this cycle,
      // is stale and must be discarded on arrival.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      drop_d     = inflight_nxt;
      issue_pc_d = redirect_word;
      rsp_pc_d   = redirect_word;
    end else begin
      if (req_fire) issue_pc_d = issue_pc_q + 32'd4;
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (mem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      issue_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      issue_pc_q <= issue_pc_d;
      rsp_pc_q   <= rsp_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= rsp_pc_q;
      instr_mem[wr_ptr_q] <= mem_rsp_data;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == CW'(DEPTH))));

  a_rsp_expected : assert property (@(posedge clk) disable iff (rst)
    !(mem_rsp_valid && (inflight_q == '0)));

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
module tb_instr_prefetch_buffer;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_instr    (fetch_instr),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  rsp_t        memq[$];
  logic [63:0] expq[$];

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          lat    = 1;
  int          last_due = 0;
  int          acc_cnt  = 0;
  logic [31:0] first_acc;
  logic [31:0] exp_issue = RESET_PC;
  logic        seen_fetch = 1'b0;
  logic [31:0] first_fetch_pc;
  logic [31:0] held;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Observes the handshakes of the current cycle and advances the model.
  task automatic sample();
    logic [63:0] e;
    int          due;
    if (mem_rsp_valid && memq.size() > 0) void'(memq.pop_front());
    if (rst) begin
      memq.delete();
      expq.delete();
      exp_issue = RESET_PC;
      last_due  = 0;
    end else begin
      if (fetch_valid && fetch_ready) begin
        if (expq.size() == 0) begin
          chk("fetch_expected", 32'(expq.size()), 32'd1);
        end else begin
          e = expq.pop_front();
          chk("fetch_pc", fetch_pc, e[63:32]);
          chk("fetch_instr", fetch_instr, e[31:0]);
        end
        if (!seen_fetch) begin
          seen_fetch     = 1'b1;
          first_fetch_pc = fetch_pc;
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        chk("req_addr", mem_req_addr, exp_issue);
        if (acc_cnt == 0) first_acc = mem_req_addr;
        acc_cnt++;
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        memq.push_back('{mem_word(mem_req_addr), due});
        expq.push_back({exp_issue, mem_word(exp_issue)});
        exp_issue = exp_issue + 32'd4;
      end
      if (redirect_valid) begin
        expq.delete();
        exp_issue = redirect_pc & 32'hFFFF_FFFC;
      end
    end
  endtask

  task automatic drive_mem();
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = memq[0].data;
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
    drive_mem();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    acc_cnt    = 0;
    seen_fetch = 1'b0;
    #1;
  endtask

  task automatic redirect_cycle(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    #1;
    chk("redir_req_valid", 32'(mem_req_valid), 32'd0);
    chk("redir_fetch_valid", 32'(fetch_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    seen_fetch     = 1'b0;
    acc_cnt        = 0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    fetch_ready    = 1'b1;
    mem_req_ready  = 1'b1;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'h0;

    // Streaming with 1-cycle memory and a ready core.
    lat = 1;
    do_reset();
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fetch_pc", fetch_pc, 32'h0);
    chk("rst_fetch_instr", fetch_instr, 32'h0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd1);
    chk("rst_req_addr", mem_req_addr, RESET_PC);
    run(2);
    chk("c2_fetch_valid", 32'(fetch_valid), 32'd1);
    chk("c2_fetch_pc", fetch_pc, 32'h0);
    for (int i = 0; i < 12; i++) begin
      chk("stream_req_valid", 32'(mem_req_valid), 32'd1);
      tick();
    end

    // Core stalled from reset: credit limits requests to DEPTH.
    fetch_ready = 1'b0;
    do_reset();
    run(10);
    chk("stall_req_count", 32'(acc_cnt), 32'd4);
    chk("stall_req_valid", 32'(mem_req_valid), 32'd0);
    chk("stall_head_pc", fetch_pc, 32'h0);
    fetch_ready = 1'b1;
    acc_cnt = 0;
    run(10);
    chk("resume_first_req", first_acc, 32'h10);

    // Redirect with two requests in flight on a 3-cycle memory.
    lat = 3;
    do_reset();
    run(2);
    redirect_cycle(32'h100);
    run(12);
    chk("lat3_first_req", first_acc, 32'h100);
    chk("lat3_first_fetch", first_fetch_pc, 32'h100);

    // Redirect coinciding with a response and a ready core, FIFO non-empty.
    lat = 1;
    fetch_ready = 1'b0;
    do_reset();
    run(3);
    chk("pre_redir_rsp_valid", 32'(mem_rsp_valid), 32'd1);
    chk("pre_redir_fetch_valid", 32'(fetch_valid), 32'd1);
    fetch_ready = 1'b1;
    redirect_cycle(32'h200);
    chk("post_redir_empty", 32'(fetch_valid), 32'd0);
    chk("post_redir_pc", fetch_pc, 32'h0);
    run(10);
    chk("redir200_first_fetch", first_fetch_pc, 32'h200);

    // Memory back-pressure: address held, single accept on release.
    mem_req_ready = 1'b0;
    acc_cnt = 0;
    held = exp_issue;
    for (int i = 0; i < 5; i++) begin
      chk("bp_addr_held", mem_req_addr, held);
      chk("bp_req_valid", 32'(mem_req_valid), 32'd1);
      tick();
    end
    chk("bp_no_accept", 32'(acc_cnt), 32'd0);
    mem_req_ready = 1'b1;
    tick();
    chk("bp_one_accept", 32'(acc_cnt), 32'd1);
    chk("bp_addr_next", mem_req_addr, held + 32'd4);
    run(8);

    // Address wrap, alignment of the redirect target, reset mid-stream.
    redirect_cycle(32'hFFFF_FFFC);
    chk("wrap_req0", mem_req_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_req1", mem_req_addr, 32'h0000_0000);
    run(8);
    chk("wrap_first_fetch", first_fetch_pc, 32'hFFFF_FFFC);
    redirect_cycle(32'h103);
    chk("align_req", mem_req_addr, 32'h100);
    run(8);
    chk("align_first_fetch", first_fetch_pc, 32'h100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen_fetch = 1'b0;
    #1;
    chk("midrst_req_addr", mem_req_addr, RESET_PC);
    chk("midrst_req_valid", 32'(mem_req_valid), 32'd1);
    chk("midrst_fetch_valid", 32'(fetch_valid), 32'd0);
    run(10);
    chk("midrst_first_fetch", first_fetch_pc, RESET_PC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
